// File: rtl/bin_to_bcd.sv
// Unsigned binary to packed BCD converter: unrolled double-dabble network, one output register.
module bin_to_bcd #(
  parameter int unsigned BINARY_LENGTH = 8,
  parameter int unsigned NUM_OF_DIGIT  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BINARY_LENGTH-1:0]    binary,
  output logic [NUM_OF_DIGIT*4-1:0]   bcd,
  output logic                        overflow
);

  // Decimal digits required to hold 2^bits-1.
  function automatic int unsigned digits_for(input int unsigned bits);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << bits) - 64'd1;
    n = 1;
    v = v / 64'd10;
    while (v != 64'd0) begin
      n = n + 1;
      v = v / 64'd10;
    end
    return n;
  endfunction

  localparam int unsigned NEED_DIGITS = digits_for(BINARY_LENGTH);
  localparam int unsigned SCR_DIGITS  = (NUM_OF_DIGIT > NEED_DIGITS) ? NUM_OF_DIGIT : NEED_DIGITS;
  localparam int unsigned SW          = SCR_DIGITS * 4;
  localparam int unsigned OW          = NUM_OF_DIGIT * 4;

  logic [SW-1:0] full_c;
  logic [OW-1:0] bcd_c;
  logic          overflow_c;

  // One adjust-then-shift stage per input bit, MSB first.
  for (genvar i = 0; i < BINARY_LENGTH; i++) begin : g_iter
    logic [SW-1:0] prev;
    logic [SW-1:0] adj;
    logic [SW-1:0] nxt;

    if (i == 0) begin : g_first
      assign prev = '0;
    end else begin : g_chain
      assign prev = g_iter[i-1].nxt;
    end

    for (genvar d = 0; d < SCR_DIGITS; d++) begin : g_dig
      assign adj[4*d +: 4] = (prev[4*d +: 4] >= 4'd5) ? (prev[4*d +: 4] + 4'd3)
                                                     : prev[4*d +: 4];
    end

    // Scratch is wide enough that the dropped top bit is always zero.
    assign nxt = SW'({adj, binary[BINARY_LENGTH-1-i]});
  end

  assign full_c = g_iter[BINARY_LENGTH-1].nxt;
  assign bcd_c  = full_c[OW-1:0];

  // Any nonzero digit above the output window means the value does not fit.
  if (SCR_DIGITS > NUM_OF_DIGIT) begin : g_ovf
    assign overflow_c = |full_c[SW-1:OW];
  end else begin : g_no_ovf
    assign overflow_c = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      bcd      <= bcd_c;
      overflow <= overflow_c;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: five configurations checked every cycle against a decimal model.
module tb_bin_to_bcd;

  localparam int NDUT = 5;
  localparam int BLS[NDUT] = '{5, 6, 14, 4, 10};
  localparam int NDS[NDUT] = '{2, 2, 4, 2, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bin_in [NDUT];
  logic [39:0] act_bcd [NDUT];
  logic        act_ov [NDUT];
  logic [39:0] exp_bcd [NDUT];
  logic        exp_ov [NDUT];
  logic        valid = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bcd0, bcd1, bcd3;
  logic [15:0] bcd2;
  logic [11:0] bcd4;
  logic        ov0, ov1, ov2, ov3, ov4;

  always #5 clk = ~clk;

  bin_to_bcd #(.BINARY_LENGTH(5),  .NUM_OF_DIGIT(2)) u_d0 (.clk(clk), .rst(rst), .binary(bin_in[0][4:0]),  .bcd(bcd0), .overflow(ov0));
  bin_to_bcd #(.BINARY_LENGTH(6),  .NUM_OF_DIGIT(2)) u_d1 (.clk(clk), .rst(rst), .binary(bin_in[1][5:0]),  .bcd(bcd1), .overflow(ov1));
  bin_to_bcd #(.BINARY_LENGTH(14), .NUM_OF_DIGIT(4)) u_d2 (.clk(clk), .rst(rst), .binary(bin_in[2][13:0]), .bcd(bcd2), .overflow(ov2));
  bin_to_bcd #(.BINARY_LENGTH(4),  .NUM_OF_DIGIT(2)) u_d3 (.clk(clk), .rst(rst), .binary(bin_in[3][3:0]),  .bcd(bcd3), .overflow(ov3));
  bin_to_bcd #(.BINARY_LENGTH(10), .NUM_OF_DIGIT(3)) u_d4 (.clk(clk), .rst(rst), .binary(bin_in[4][9:0]),  .bcd(bcd4), .overflow(ov4));

  assign act_bcd[0] = 40'(bcd0);
  assign act_bcd[1] = 40'(bcd1);
  assign act_bcd[2] = 40'(bcd2);
  assign act_bcd[3] = 40'(bcd3);
  assign act_bcd[4] = 40'(bcd4);
  assign act_ov[0]  = ov0;
  assign act_ov[1]  = ov1;
  assign act_ov[2]  = ov2;
  assign act_ov[3]  = ov3;
  assign act_ov[4]  = ov4;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  // Decimal digits of v, lowest nd digits, one per nibble.
  function automatic logic [39:0] ref_bcd(input longint unsigned v, input int nd);
    logic [39:0] r = '0;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(v % 64'd10);
      v = v / 64'd10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered reference: what each output must hold after this edge.
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      longint unsigned v;
      v = longint'(bin_in[i]) & ((64'd1 << BLS[i]) - 64'd1);
      if (!rst) begin
        exp_bcd[i] = '0;
        exp_ov[i]  = 1'b0;
      end else begin
        exp_bcd[i] = ref_bcd(v, NDS[i]);
        exp_ov[i]  = (v >= pow10(NDS[i]));
      end
    end
    valid = 1'b1;
  end

  always @(negedge clk) begin
    if (valid) begin
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("model_bcd[%0d]", i), act_bcd[i], exp_bcd[i]);
        check($sformatf("model_ovf[%0d]", i), 40'(act_ov[i]), 40'(exp_ov[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_year(input int v, input logic [15:0] eb, input logic eo);
    bin_in[2] = 32'(v);
    step();
    check($sformatf("year_bcd_%0d", v), act_bcd[2], 40'(eb));
    check($sformatf("year_ovf_%0d", v), 40'(act_ov[2]), 40'(eo));
  endtask

  initial begin
    logic [7:0] tf_exp [5];
    int         tf_in  [5];
    tf_in  = '{0, 9, 10, 59, 63};
    tf_exp = '{8'h00, 8'h09, 8'h10, 8'h59, 8'h63};

    for (int i = 0; i < NDUT; i++) bin_in[i] = '0;

    // Pin the model against hand-computed values.
    check("pin_model_12345", ref_bcd(64'd12345, 4), 40'h2345);
    check("pin_model_1023",  ref_bcd(64'd1023, 3),  40'h023);
    check("pin_model_ovf",   40'(64'd12345 >= pow10(4)), 40'd1);

    // Reset held three cycles with a nonzero input.
    rst = 1'b0;
    bin_in[0] = 32'd23;
    repeat (3) step();
    check("reset_bcd", act_bcd[0], 40'h00);
    check("reset_ovf", 40'(act_ov[0]), 40'd0);
    rst = 1'b1;
    step();
    check("after_reset_23", act_bcd[0], 40'h23);
    bin_in[0] = 32'd31;
    step();
    check("allones_5b", act_bcd[0], 40'h31);

    // Time fields.
    for (int i = 0; i < 5; i++) begin
      bin_in[1] = 32'(tf_in[i]);
      step();
      check($sformatf("time_bcd_%0d", tf_in[i]), act_bcd[1], 40'(tf_exp[i]));
      check($sformatf("time_ovf_%0d", tf_in[i]), 40'(act_ov[1]), 40'd0);
    end

    // Year and overflow boundaries.
    apply_year(2024,  16'h2024, 1'b0);
    apply_year(9999,  16'h9999, 1'b0);
    apply_year(10000, 16'h0000, 1'b1);
    apply_year(16383, 16'h6383, 1'b1);
    apply_year(12345, 16'h2345, 1'b1);
    apply_year(0,     16'h0000, 1'b0);

    // Month-width sweep.
    for (int i = 0; i < 16; i++) begin
      bin_in[3] = 32'(i);
      step();
      check($sformatf("month_%0d", i), act_bcd[3], 40'({4'(i / 10), 4'(i % 10)}));
    end

    // Exhaustive back-to-back stream on the 10-bit instance.
    for (int i = 0; i < 1024; i++) begin
      bin_in[4] = 32'(i);
      step();
    end
    check("exh_last_1023", act_bcd[4], 40'h023);
    check("exh_last_ovf",  40'(act_ov[4]), 40'd1);

    // Random stream with a one-cycle reset pulse.
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NDUT; i++) bin_in[i] = $urandom;
      rst = (n == 100) ? 1'b0 : 1'b1;
      step();
      if (n == 100) begin
        for (int i = 0; i < NDUT; i++) begin
          check($sformatf("midrst_bcd[%0d]", i), act_bcd[i], 40'h0);
          check($sformatf("midrst_ovf[%0d]", i), 40'(act_ov[i]), 40'd0);
        end
      end
    end
    rst = 1'b1;
    bin_in[2] = 32'd1999;
    step();
    check("post_rand_1999", act_bcd[2], 40'h1999);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
- Parameterised unsigned binary-to-packed-BCD converter with a registered output.
- Used by clock/alarm logic to turn binary time and date fields into BCD for comparison against BCD-stored settings and for display.
- Conversion is a fully unrolled shift-and-add-3 (double-dabble) network in a single combinational stage, followed by one output register stage.

Parameters:
- BINARY_LENGTH, default 8: width of the unsigned binary input in bits; legal range 1..32.
- NUM_OF_DIGIT, default 3: number of BCD digits produced; legal range 1..10.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- binary  input  BINARY_LENGTH  unsigned value to convert.
- bcd  output  NUM_OF_DIGIT*4  packed BCD result. Digit k occupies bcd[4k+3:4k]; digit 0 is the units digit.
- overflow  output  1  high when the registered value exceeds 10^NUM_OF_DIGIT - 1.

Behaviour:
- Reset: on a clk rising edge with rst=0, bcd <= 0 and overflow <= 0. Reset takes priority over any conversion.
  - Reset mid-stream discards the in-flight result.
  - The first valid result appears one cycle after rst returns high.
- Latency: exactly 1 clock.
  - bcd and overflow at edge n+1 reflect binary sampled at edge n.
  - A new input is accepted every cycle; there is no handshake.
  - The output holds while the input is stable.
- Conversion algorithm: internal scratch of NUM_OF_DIGIT*4 digit bits plus enough extra digit positions to represent 2^BINARY_LENGTH-1 fully.
  - Iterate BINARY_LENGTH times, MSB first.
  - In each iteration, first add 3 to every digit nibble that is >= 5, then shift left by one, bringing in the next binary bit.
  - Elaborate as generate loops; no loops over runtime values.
- Output digits: bcd carries the low NUM_OF_DIGIT digits of the decimal value, i.e. value mod 10^NUM_OF_DIGIT.
  - Every nibble is always in the range 0..9; never emit A..F.
- Overflow: asserted, registered with the same latency, when binary > 10^NUM_OF_DIGIT - 1.
  - Example: BINARY_LENGTH=14, NUM_OF_DIGIT=4, input 12345 -> bcd 16'h2345, overflow=1.
  - If 2^BINARY_LENGTH-1 <= 10^NUM_OF_DIGIT-1, overflow is constant 0 after reset.
- Surplus digits: when NUM_OF_DIGIT exceeds the digits needed for the input range, the upper digits are 0.
- Boundaries:
  - binary=0 -> bcd all zero.
  - binary=all ones -> correct decimal of 2^BINARY_LENGTH-1, truncated as above.
  - binary = 10^NUM_OF_DIGIT-1 -> all nines, overflow=0.
  - binary = 10^NUM_OF_DIGIT -> all zeros, overflow=1.
- Inputs with X/Z are not supported; the output is then undefined.
- No other state: the block is a pure function plus a register.

Test Plan:
- Reset: hold rst=0 for 3 cycles with binary=5'd23 (BINARY_LENGTH=5, NUM_OF_DIGIT=2) -> bcd=8'h00, overflow=0. Release rst -> bcd=8'h23 after 1 cycle.
- Time fields: BINARY_LENGTH=6, NUM_OF_DIGIT=2; apply 0, 9, 10, 59, 63 on consecutive cycles -> bcd 8'h00, 8'h09, 8'h10, 8'h59, 8'h63 each one cycle later; overflow=0 throughout.
- Year/overflow: BINARY_LENGTH=14, NUM_OF_DIGIT=4.
  - 2024 -> 16'h2024, overflow 0.
  - 9999 -> 16'h9999, overflow 0.
  - 10000 -> 16'h0000, overflow 1.
  - 16383 -> 16'h6383, overflow 1.
- Month/small width: BINARY_LENGTH=4, NUM_OF_DIGIT=2; sweep 0..15 -> 8'h00..8'h15 with correct decimal values (e.g. 12 -> 8'h12). No nibble above 9.
- Exhaustive: BINARY_LENGTH=10, NUM_OF_DIGIT=3; all 1024 inputs back-to-back.
  - Compare against a reference model (value mod 1000 in BCD, overflow for >999), with a 1-cycle latency check on every cycle.
- Reset mid-operation: stream random values, drop rst low for 1 cycle -> outputs 0 on that edge only. The conversion of the input present on the following edge appears normally.
